// File: rtl/mips_dmem_responder.sv
// MEM-stage data responder for the pipelined MIPS core: word RAM plus an MMIO block
// holding an LED register, a free-running timer with compare, and a sticky status register.
module mips_dmem_responder #(
  parameter int unsigned RAM_WORDS    = 64,
  parameter int unsigned RAM_AW       = 6,
  parameter logic [15:0] MMIO_BASE_HI = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic [7:0]  led,
  output logic        irq
);

  // MMIO register select uses the word offset so the byte lane bits never change the target
  localparam logic [13:0] OffLed    = 14'h0000;
  localparam logic [13:0] OffCount  = 14'h0001;
  localparam logic [13:0] OffCtrl   = 14'h0002;
  localparam logic [13:0] OffCmp    = 14'h0003;
  localparam logic [13:0] OffStatus = 14'h0004;

  logic [31:0] r_ram [RAM_WORDS];

  logic [7:0]  r_led;
  logic [31:0] r_count;
  logic [1:0]  r_ctrl;
  logic [31:0] r_cmp;
  logic [1:0]  r_status;

  logic [7:0]  w_led_d;
  logic [31:0] w_count_d;
  logic [1:0]  w_ctrl_d;
  logic [31:0] w_cmp_d;
  logic [1:0]  w_status_d;

  logic              w_mmio_sel;
  logic [13:0]       w_word;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_misalign;
  logic              w_wr_ram;
  logic              w_wr_led;
  logic              w_wr_count;
  logic              w_wr_ctrl;
  logic              w_wr_cmp;
  logic              w_wr_status;
  logic              w_match_set;
  logic [1:0]        w_status_clr;
  logic [1:0]        w_status_set;

  assign w_mmio_sel = (memaddr[31:16] == MMIO_BASE_HI);
  assign w_word     = memaddr[15:2];
  assign w_ram_idx  = memaddr[RAM_AW+1:2];
  assign w_misalign = (memaddr[1:0] != 2'b00);

  assign w_wr_ram    = memwrite & ~w_mmio_sel;
  assign w_wr_led    = memwrite & w_mmio_sel & (w_word == OffLed);
  assign w_wr_count  = memwrite & w_mmio_sel & (w_word == OffCount);
  assign w_wr_ctrl   = memwrite & w_mmio_sel & (w_word == OffCtrl);
  assign w_wr_cmp    = memwrite & w_mmio_sel & (w_word == OffCmp);
  assign w_wr_status = memwrite & w_mmio_sel & (w_word == OffStatus);

  // Contents are deliberately not reset; a store racing reset leaves only that word undefined
  always_ff @(posedge clk) begin
    if (w_wr_ram) begin
      r_ram[w_ram_idx] <= memwritedata;
    end
  end

  // Match compares pre-edge COUNT/CMP, so a same-cycle store to either is seen next cycle
  assign w_match_set  = r_ctrl[0] & (r_count == r_cmp);
  assign w_status_clr = w_wr_status ? memwritedata[1:0] : 2'b00;
  assign w_status_set = {memwrite & w_misalign, w_match_set};

  always_comb begin
    w_led_d    = r_led;
    w_count_d  = r_count;
    w_ctrl_d   = r_ctrl;
    w_cmp_d    = r_cmp;
    w_status_d = (r_status & ~w_status_clr) | w_status_set;

    if (w_wr_led) begin
      w_led_d = memwritedata[7:0];
    end
    if (w_wr_count) begin
      w_count_d = memwritedata;
    end else if (r_ctrl[0]) begin
      w_count_d = r_count + 32'd1;
    end
    if (w_wr_ctrl) begin
      w_ctrl_d = memwritedata[1:0];
    end
    if (w_wr_cmp) begin
      w_cmp_d = memwritedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led    <= 8'h00;
      r_count  <= 32'h0000_0000;
      r_ctrl   <= 2'b00;
      r_cmp    <= 32'h0000_0000;
      r_status <= 2'b00;
    end else begin
      r_led    <= w_led_d;
      r_count  <= w_count_d;
      r_ctrl   <= w_ctrl_d;
      r_cmp    <= w_cmp_d;
      r_status <= w_status_d;
    end
  end

  always_comb begin
    memreaddata = 32'h0000_0000;
    if (w_mmio_sel) begin
      case (w_word)
        OffLed:    memreaddata = {24'h00_0000, r_led};
        OffCount:  memreaddata = r_count;
        OffCtrl:   memreaddata = {30'h0, r_ctrl};
        OffCmp:    memreaddata = r_cmp;
        OffStatus: memreaddata = {30'h0, r_status};
        default:   memreaddata = 32'h0000_0000;
      endcase
    end else begin
      memreaddata = r_ram[w_ram_idx];
    end
  end

  assign led = r_led;
  assign irq = r_status[0] & r_ctrl[1];

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder: expected load data is queued when the
// address is driven and popped when the combinational read is sampled.
module tb_mips_dmem_responder;

  localparam logic [31:0] ALed    = 32'hFFFF_0000;
  localparam logic [31:0] ACount  = 32'hFFFF_0004;
  localparam logic [31:0] ACtrl   = 32'hFFFF_0008;
  localparam logic [31:0] ACmp    = 32'hFFFF_000C;
  localparam logic [31:0] AStatus = 32'hFFFF_0010;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic [7:0]  led;
  logic        irq;

  logic [31:0] q_exp[$];
  logic [31:0] e;
  int          errors;
  int          checks;

  mips_dmem_responder #(
    .RAM_WORDS   (64),
    .RAM_AW      (6),
    .MMIO_BASE_HI(16'hFFFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .memaddr     (memaddr),
    .memwritedata(memwritedata),
    .memreaddata (memreaddata),
    .led         (led),
    .irq         (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one store cycle; returns just after the committing edge
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite     = 1'b1;
    memaddr      = a;
    memwritedata = d;
    @(posedge clk);
    #1;
    memwrite     = 1'b0;
    memwritedata = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    memwrite = 1'b0;
    memwritedata = 32'h0;
    memaddr = ALed;
    q_exp.push_back(32'h0);
    #2;
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL reset_led_read got=%h exp=%h", memreaddata, e);
    end
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL reset_led got=%h exp=00", led);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    foreach (q_exp[i]) q_exp.delete(i);
    for (int i = 0; i < 3; i++) begin
      memaddr = (i == 0) ? ACount : (i == 1) ? ACtrl : AStatus;
      q_exp.push_back(32'h0);
      #1;
      e = q_exp.pop_front();
      checks++;
      if (memreaddata !== e) begin
        errors++;
        $display("FAIL reset_reg%0d got=%h exp=%h", i, memreaddata, e);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_ram();
    store(32'h0000_0010, 32'h1234_5678);
    memaddr = 32'h0000_0010;
    q_exp.push_back(32'h1234_5678);
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL ram_load got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
    memaddr = 32'h0000_0110;
    q_exp.push_back(32'h1234_5678);
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL ram_alias got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
    // Read-during-write returns the old word, new word visible next cycle
    memwrite = 1'b1;
    memaddr = 32'h0000_0010;
    memwritedata = 32'hCAFE_F00D;
    q_exp.push_back(32'h1234_5678);
    q_exp.push_back(32'hCAFE_F00D);
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL ram_rdw_old got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
    memwrite = 1'b0;
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL ram_rdw_new got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
  endtask

  task automatic test_led();
    store(ALed, 32'h0000_00A5);
    memaddr = ALed;
    q_exp.push_back(32'h0000_00A5);
    @(negedge clk);
    checks++;
    if (led !== 8'hA5) begin
      errors++;
      $display("FAIL led_out got=%h exp=a5", led);
    end
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL led_read got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
    memaddr = 32'hFFFF_0020;
    q_exp.push_back(32'h0);
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL mmio_unmapped got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
  endtask

  task automatic test_timer();
    logic exp_irq;
    store(ACmp, 32'd5);
    store(ACtrl, 32'd3);
    for (int k = 0; k < 8; k++) begin
      memaddr = ACount;
      q_exp.push_back(32'(k));
      exp_irq = (k >= 6);
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if (memreaddata !== e) begin
        errors++;
        $display("FAIL timer_count%0d got=%h exp=%h", k, memreaddata, e);
      end
      checks++;
      if (irq !== exp_irq) begin
        errors++;
        $display("FAIL timer_irq%0d got=%b exp=%b", k, irq, exp_irq);
      end
      next_cycle();
    end
    memaddr = AStatus;
    q_exp.push_back(32'h1);
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL timer_status got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
    store(AStatus, 32'h1);
    memaddr = AStatus;
    q_exp.push_back(32'h0);
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL timer_w1c got=%h exp=%h", memreaddata, e);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL timer_irq_clr got=%b exp=0", irq);
    end
    for (int k = 11; k < 13; k++) begin
      next_cycle();
      memaddr = ACount;
      q_exp.push_back(32'(k));
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if (memreaddata !== e) begin
        errors++;
        $display("FAIL timer_continue got=%h exp=%h", memreaddata, e);
      end
    end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [31:0] seq [4];
    seq[0] = 32'hFFFF_FFFE;
    seq[1] = 32'hFFFF_FFFF;
    seq[2] = 32'h0000_0000;
    seq[3] = 32'h0000_0001;
    store(ACount, 32'hFFFF_FFFE);
    for (int k = 0; k < 4; k++) begin
      memaddr = ACount;
      q_exp.push_back(seq[k]);
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if (memreaddata !== e) begin
        errors++;
        $display("FAIL wrap_count%0d got=%h exp=%h", k, memreaddata, e);
      end
      next_cycle();
    end
    memaddr = AStatus;
    q_exp.push_back(32'h0);
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL wrap_no_match got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
    store(ACtrl, 32'h0);
    for (int k = 0; k < 2; k++) begin
      memaddr = ACount;
      q_exp.push_back(32'd4);
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if (memreaddata !== e) begin
        errors++;
        $display("FAIL timer_stopped got=%h exp=%h", memreaddata, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_misalign();
    store(32'h0000_0022, 32'hDEAD_BEEF);
    memaddr = 32'h0000_0020;
    q_exp.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL misalign_data got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
    memaddr = AStatus;
    q_exp.push_back(32'h2);
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL misalign_status got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
    store(AStatus, 32'h2);
    memaddr = AStatus;
    q_exp.push_back(32'h0);
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL misalign_w1c got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
  endtask

  task automatic test_set_wins();
    // Misaligned W1C of misalign: set and clear collide, set wins
    store(AStatus + 32'd2, 32'h2);
    memaddr = AStatus;
    q_exp.push_back(32'h2);
    @(negedge clk);
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL set_wins got=%h exp=%h", memreaddata, e);
    end
    next_cycle();
    store(ALed + 32'd2, 32'h0000_003C);
    checks++;
    if (led !== 8'h3C) begin
      errors++;
      $display("FAIL misalign_led got=%h exp=3c", led);
    end
    store(AStatus, 32'h2);
  endtask

  task automatic test_reset_mid();
    store(ACmp, 32'h3E);
    store(ACount, 32'h3C);
    store(ACtrl, 32'h3);
    for (int k = 0; k < 4; k++) next_cycle();
    memaddr = ACount;
    q_exp.push_back(32'h40);
    q_exp.push_back(32'h0);
    #1;
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL mid_count_pre got=%h exp=%h", memreaddata, e);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL mid_irq_pre got=%b exp=1", irq);
    end
    reset = 1'b0;
    #1;
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL mid_count_rst got=%h exp=%h", memreaddata, e);
    end
    checks++;
    if (irq !== 1'b0 || led !== 8'h00) begin
      errors++;
      $display("FAIL mid_irq_led got=%b/%h exp=0/00", irq, led);
    end
    memaddr = AStatus;
    q_exp.push_back(32'h0);
    #1;
    e = q_exp.pop_front();
    checks++;
    if (memreaddata !== e) begin
      errors++;
      $display("FAIL mid_status_rst got=%h exp=%h", memreaddata, e);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      memaddr = ACount;
      q_exp.push_back(32'h0);
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if (memreaddata !== e) begin
        errors++;
        $display("FAIL post_rst_idle got=%h exp=%h", memreaddata, e);
      end
    end
    next_cycle();
    store(ACtrl, 32'h1);
    for (int k = 0; k < 2; k++) begin
      memaddr = ACount;
      q_exp.push_back(32'(k));
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if (memreaddata !== e) begin
        errors++;
        $display("FAIL post_rst_count got=%h exp=%h", memreaddata, e);
      end
      next_cycle();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_ram();
    test_led();
    test_timer();
    test_wrap();
    test_misalign();
    test_set_wins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
